// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code sequencing path.
package gray_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int GRAY_MAX_W = 32;

    // Callers zero-extend narrower values and keep the low bits of the result.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/bin_to_gray_w.sv
// W-wide combinational binary-to-Gray converter (W <= 32).
module bin_to_gray_w
    import gray_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] bin,
    output logic [W-1:0] gray
);

    assign gray = W'(bin2gray(GRAY_MAX_W'(bin)));

endmodule

// File: rtl/gray_seq_counter.sv
// Sequenced up/down counter with a registered Gray copy, step-count/free-run
// modes, parallel load and wrap indication.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; count holds
// ST_RUN  | stepping once per edge; remaining==0 means free-run
// ST_DONE | step-count run finished; emits done on the way back to IDLE
module gray_seq_counter
    import gray_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         stop,
    input  logic         dir,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] steps,
    output logic [W-1:0] bin_q,
    output logic [W-1:0] gray_q,
    output logic         busy,
    output logic         done,
    output logic         wrap
);

    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] remaining;
    logic [W-1:0] remaining_nxt;
    logic [W-1:0] bin_nxt;
    logic [W-1:0] gray_nxt;
    logic         wrap_nxt;

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        bin_nxt       = bin_q;
        wrap_nxt      = 1'b0;
        if (load) begin
            bin_nxt       = load_val;
            remaining_nxt = '0;
            state_nxt     = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        remaining_nxt = steps;
                        state_nxt     = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        if (dir == DIR_DOWN) begin
                            bin_nxt  = bin_q - ONE;
                            wrap_nxt = (bin_q == '0);
                        end else begin
                            bin_nxt  = bin_q + ONE;
                            wrap_nxt = (bin_q == ALL_ONES);
                        end
                        if (remaining != '0) begin
                            remaining_nxt = remaining - ONE;
                            if (remaining == ONE) state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Converting the next value keeps gray_q in step with bin_q on every edge.
    bin_to_gray_w #(.W(W)) u_bin_to_gray (
        .bin  (bin_nxt),
        .gray (gray_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
            bin_q     <= '0;
            gray_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            bin_q     <= bin_nxt;
            gray_q    <= gray_nxt;
            busy      <= (state_nxt == ST_RUN);
            done      <= (state == ST_DONE);
            wrap      <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_gray_seq_counter.sv
// Self-checking bench for gray_seq_counter: scenario tasks against an arithmetic model.
module tb_gray_seq_counter;

    localparam int W  = 4;
    localparam int M  = 16;
    localparam int OW = 2 * W + 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         dir = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] steps = '0;
    logic [W-1:0] bin_q;
    logic [W-1:0] gray_q;
    logic         busy;
    logic         done;
    logic         wrap;

    int errors = 0;
    int checks = 0;

    gray_seq_counter #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .steps    (steps),
        .bin_q    (bin_q),
        .gray_q   (gray_q),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_gray(input int v);
        logic [W-1:0] b;
        b = W'(v);
        return b ^ (b >> 1);
    endfunction

    function automatic int modm(input int v);
        return ((v % M) + M) % M;
    endfunction

    function automatic logic [OW-1:0] pack(input int b, input logic bz, input logic dn, input logic wr);
        return {W'(b), ref_gray(b), bz, dn, wr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [OW-1:0] exp;
        load = 1'b1; load_val = 4'd5; tick(); load = 1'b0;
        start = 1'b1; steps = '0; dir = 1'b0; tick(); start = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; exp = pack(0, 0, 0, 0);
        if ({bin_q, gray_q, busy, done, wrap} !== exp) begin
            errors++; $display("FAIL reset_async: got %b expected %b", {bin_q, gray_q, busy, done, wrap}, exp);
        end
        @(negedge clk); rst_n = 1'b1;
        tick();
        checks++;
        if ({bin_q, gray_q, busy, done, wrap} !== exp) begin
            errors++; $display("FAIL reset_release: got %b expected %b", {bin_q, gray_q, busy, done, wrap}, exp);
        end
        start = 1'b1; steps = '0; dir = 1'b0; tick(); start = 1'b0;
        checks++; exp = pack(0, 1, 0, 0);
        if ({bin_q, gray_q, busy, done, wrap} !== exp) begin
            errors++; $display("FAIL reset_start_edge: got %b expected %b", {bin_q, gray_q, busy, done, wrap}, exp);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++; exp = pack(k, 1, 0, 0);
            if ({bin_q, gray_q, busy, done, wrap} !== exp) begin
                errors++; $display("FAIL reset_freerun k=%0d: got %b expected %b", k, {bin_q, gray_q, busy, done, wrap}, exp);
            end
        end
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic test_step_count();
        logic [OW-1:0] exp;
        int v, n, b, raw, s;
        logic d, w;
        for (int c = 0; c < 6; c++) begin
            if (c == 0) begin v = 3; n = 5; d = 1'b0; end
            else begin v = $urandom_range(0, M - 1); n = $urandom_range(1, M - 1); d = 1'($urandom_range(0, 1)); end
            load = 1'b1; load_val = W'(v); tick(); load = 1'b0;
            start = 1'b1; steps = W'(n); dir = d; tick(); start = 1'b0;
            checks++; exp = pack(v, 1, 0, 0);
            if ({bin_q, gray_q, busy, done, wrap} !== exp) begin
                errors++; $display("FAIL step_start c=%0d: got %b expected %b", c, {bin_q, gray_q, busy, done, wrap}, exp);
            end
            b = v; s = d ? -1 : 1;
            for (int k = 1; k <= n; k++) begin
                raw = b + s; w = (raw < 0) || (raw >= M); b = modm(raw);
                tick();
                checks++; exp = pack(b, k < n, 0, w);
                if ({bin_q, gray_q, busy, done, wrap} !== exp) begin
                    errors++; $display("FAIL step_run c=%0d k=%0d: got %b expected %b", c, k, {bin_q, gray_q, busy, done, wrap}, exp);
                end
            end
            tick();
            checks++; exp = pack(b, 0, 1, 0);
            if ({bin_q, gray_q, busy, done, wrap} !== exp) begin
                errors++; $display("FAIL step_done c=%0d: got %b expected %b", c, {bin_q, gray_q, busy, done, wrap}, exp);
            end
            tick();
            checks++; exp = pack(b, 0, 0, 0);
            if ({bin_q, gray_q, busy, done, wrap} !== exp) begin
                errors++; $display("FAIL step_idle c=%0d: got %b expected %b", c, {bin_q, gray_q, busy, done, wrap}, exp);
            end
        end
    endtask

    task automatic test_wrap();
        logic [OW-1:0] exp;
        int ups [3]   = '{15, 0, 1};
        int downs [3] = '{0, 15, 14};
        load = 1'b1; load_val = 4'd14; tick(); load = 1'b0;
        start = 1'b1; steps = '0; dir = 1'b0; tick(); start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; exp = pack(ups[k], 1, 0, k == 1);
            if ({bin_q, gray_q, busy, done, wrap} !== exp) begin
                errors++; $display("FAIL wrap_up k=%0d: got %b expected %b", k, {bin_q, gray_q, busy, done, wrap}, exp);
            end
        end
        stop = 1'b1; tick(); stop = 1'b0;
        load = 1'b1; load_val = 4'd1; tick(); load = 1'b0;
        start = 1'b1; dir = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; exp = pack(downs[k], 1, 0, k == 1);
            if ({bin_q, gray_q, busy, done, wrap} !== exp) begin
                errors++; $display("FAIL wrap_down k=%0d: got %b expected %b", k, {bin_q, gray_q, busy, done, wrap}, exp);
            end
            if (k == 1) begin
                checks++;
                if (gray_q !== 4'b1000) begin
                    errors++; $display("FAIL wrap_down_gray: got %b expected 1000", gray_q);
                end
            end
        end
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic test_priority();
        logic [OW-1:0] exp;
        int b;
        load = 1'b1; load_val = 4'd2; tick(); load = 1'b0;
        start = 1'b1; steps = '0; dir = 1'b0; tick(); start = 1'b0;
        tick(); tick();
        load = 1'b1; load_val = 4'd9; stop = 1'b1; tick(); load = 1'b0; stop = 1'b0;
        checks++; exp = pack(9, 0, 0, 0);
        if ({bin_q, gray_q, busy, done, wrap} !== exp || gray_q !== 4'b1101) begin
            errors++; $display("FAIL prio_load_stop: got %b expected %b", {bin_q, gray_q, busy, done, wrap}, exp);
        end
        start = 1'b1; steps = 4'd6; tick(); start = 1'b0;
        b = 9;
        for (int k = 1; k <= 6; k++) begin
            if (k == 3) begin start = 1'b1; steps = 4'd1; end
            if (k == 5) start = 1'b0;
            b++;
            tick();
            checks++; exp = pack(b, k < 6, 0, 0);
            if ({bin_q, gray_q, busy, done, wrap} !== exp) begin
                errors++; $display("FAIL prio_start_in_run k=%0d: got %b expected %b", k, {bin_q, gray_q, busy, done, wrap}, exp);
            end
        end
        load = 1'b1; load_val = 4'd4; tick(); load = 1'b0;
        checks++; exp = pack(4, 0, 1, 0);
        if ({bin_q, gray_q, busy, done, wrap} !== exp) begin
            errors++; $display("FAIL prio_load_in_done: got %b expected %b", {bin_q, gray_q, busy, done, wrap}, exp);
        end
        tick();
        checks++; exp = pack(4, 0, 0, 0);
        if ({bin_q, gray_q, busy, done, wrap} !== exp) begin
            errors++; $display("FAIL prio_after_load: got %b expected %b", {bin_q, gray_q, busy, done, wrap}, exp);
        end
    endtask

    task automatic test_stop();
        logic [OW-1:0] exp;
        load = 1'b1; load_val = '0; tick(); load = 1'b0;
        start = 1'b1; steps = 4'd10; dir = 1'b0; tick(); start = 1'b0;
        tick(); tick(); tick();
        stop = 1'b1; tick(); stop = 1'b0;
        checks++; exp = pack(3, 0, 0, 0);
        if ({bin_q, gray_q, busy, done, wrap} !== exp) begin
            errors++; $display("FAIL stop_abort: got %b expected %b", {bin_q, gray_q, busy, done, wrap}, exp);
        end
        for (int k = 0; k < 12; k++) begin
            stop = (k == 6);
            tick();
            checks++;
            if ({bin_q, gray_q, busy, done, wrap} !== exp) begin
                errors++; $display("FAIL stop_idle k=%0d: got %b expected %b", k, {bin_q, gray_q, busy, done, wrap}, exp);
            end
        end
        stop = 1'b0;
    endtask

    task automatic test_dir_flip();
        logic [OW-1:0] exp;
        int seq [5] = '{3, 2, 1, 0, 15};
        load = 1'b1; load_val = '0; tick(); load = 1'b0;
        start = 1'b1; steps = '0; dir = 1'b0; tick(); start = 1'b0;
        repeat (4) tick();
        checks++; exp = pack(4, 1, 0, 0);
        if ({bin_q, gray_q, busy, done, wrap} !== exp) begin
            errors++; $display("FAIL flip_before: got %b expected %b", {bin_q, gray_q, busy, done, wrap}, exp);
        end
        dir = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; exp = pack(seq[k], 1, 0, k == 4);
            if ({bin_q, gray_q, busy, done, wrap} !== exp) begin
                errors++; $display("FAIL flip_down k=%0d: got %b expected %b", k, {bin_q, gray_q, busy, done, wrap}, exp);
            end
        end
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic test_random_walk();
        logic [OW-1:0] exp;
        int b, raw;
        logic w;
        b = $urandom_range(0, M - 1);
        load = 1'b1; load_val = W'(b); tick(); load = 1'b0;
        start = 1'b1; steps = '0; dir = 1'b0; tick(); start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            dir = 1'($urandom_range(0, 1));
            raw = dir ? b - 1 : b + 1;
            w = (raw < 0) || (raw >= M);
            b = modm(raw);
            tick();
            checks++; exp = pack(b, 1, 0, w);
            if ({bin_q, gray_q, busy, done, wrap} !== exp) begin
                errors++; $display("FAIL random_walk k=%0d: got %b expected %b", k, {bin_q, gray_q, busy, done, wrap}, exp);
            end
        end
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_step_count();
        test_wrap();
        test_priority();
        test_stop();
        test_dir_flip();
        test_random_walk();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
